// File: rtl/fm_demod_pkg.sv
// fm_demod_pkg
// Shared definitions for the zero-crossing FM demodulator.
// It holds the sequencing FSM state type and the default widths.
// The default widths are the ones used by the matching dds transmitter.
package fm_demod_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } div_state_t;

  localparam int DEFAULT_NBITS_PHASE  = 18;
  localparam int DEFAULT_N_INPUT_BITS = 8;
  localparam int CNT_WIDTH            = 16;

endpackage

// File: rtl/serial_divider.sv
// serial_divider
// Unsigned 32/16 restoring divider. It takes a fixed 32 iterations, one per clock.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   start     load operands and begin dividing (ignored while busy by the caller)
//   numerator 32-bit dividend
//   divisor   16-bit divisor (must be nonzero)
//   busy      high while iterations are still pending
//   done      high during the clock whose edge performs the final iteration
//   quotient  floored quotient, valid after the final iteration
module serial_divider
  import fm_demod_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          numerator,
  input  logic [CNT_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          quotient
);

  logic [CNT_WIDTH-1:0] div_reg;
  logic [CNT_WIDTH:0]   rem;
  logic [31:0]          quo;
  logic [4:0]           iter;

  logic [CNT_WIDTH+1:0] rem_shift;
  logic [CNT_WIDTH:0]   rem_next;
  logic                 fits;

  // One restoring step: bring in the next dividend bit.
  // Subtract the divisor when it fits.
  // The remainder is always below the divisor, so 17 bits hold the shifted value.
  always_comb begin
    rem_shift = {rem, quo[31]};
    fits      = rem_shift >= {2'b00, div_reg};
    rem_next  = rem_shift[CNT_WIDTH:0];
    if (fits) begin
      rem_next = (CNT_WIDTH + 1)'(rem_shift - {2'b00, div_reg});
    end
  end

  // The quotient bits shift in where the dividend bits shift out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_reg <= '0;
      rem     <= '0;
      quo     <= '0;
      iter    <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      div_reg <= divisor;
      rem     <= '0;
      quo     <= numerator;
      iter    <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      rem  <= rem_next;
      quo  <= {quo[30:0], fits};
      iter <= iter + 5'd1;
      if (iter == 5'd31) begin
        busy <= 1'b0;
      end
    end
  end

  assign done     = busy && (iter == 5'd31);
  assign quotient = quo;

endmodule

// File: rtl/fm_zc_demod.sv
// fm_zc_demod
// Zero-crossing FM demodulator. It measures the number of samples between rising
// zero crossings. It then converts that period into the estimated dds phase increment,
// 2^NBITS_PHASE / period.
// Ports:
//   clock         rising-edge system clock
//   reset         asynchronous active-low reset
//   enableclk     sample strobe, insine valid when high
//   insine        signed input sample
//   phaseinc_est  last phase-increment estimate
//   est_valid     one-clock pulse when phaseinc_est updates
//   nosignal      high while no valid crossing has been seen for MAX_PERIOD samples
//   overrun       one-clock pulse when a crossing is dropped because the divider is busy
module fm_zc_demod
  import fm_demod_pkg::*;
#(
  parameter int NBITS_PHASE  = DEFAULT_NBITS_PHASE,
  parameter int N_INPUT_BITS = DEFAULT_N_INPUT_BITS,
  parameter int HYST         = 4,
  parameter int MIN_PERIOD   = 4,
  parameter int MAX_PERIOD   = 65535
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enableclk,
  input  logic [N_INPUT_BITS-1:0] insine,
  output logic [31:0]             phaseinc_est,
  output logic                    est_valid,
  output logic                    nosignal,
  output logic                    overrun
);

  localparam logic [31:0]                    NUMERATOR = 32'd1 << NBITS_PHASE;
  localparam logic [CNT_WIDTH-1:0]           MIN_CNT   = CNT_WIDTH'(MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0]           MAX_CNT   = CNT_WIDTH'(MAX_PERIOD);
  localparam logic signed [N_INPUT_BITS-1:0] ARM_LEVEL = N_INPUT_BITS'(-HYST);

  div_state_t state, next_state;

  logic                 armed;
  logic                 seen;
  logic [CNT_WIDTH-1:0] cnt;

  logic        is_low;
  logic        crossing;
  logic        period_ok;
  logic        accepted;
  logic        fsm_busy;
  logic        launch;
  logic        saturating;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quotient;

  // Hysteresis: the input must dip to -HYST before a non-negative sample counts.
  // This keeps noise around zero from producing crossings.
  // The counter holds the samples since the last crossing. So at a crossing it holds
  // the full period.
  always_comb begin
    is_low     = $signed(insine) <= ARM_LEVEL;
    crossing   = armed && !insine[N_INPUT_BITS-1];
    period_ok  = (cnt >= MIN_CNT) && (cnt < MAX_CNT);
    accepted   = enableclk && crossing && seen && period_ok;
    fsm_busy   = (state != IDLE) || div_busy;
    launch     = accepted && !fsm_busy;
    saturating = enableclk && !crossing && (cnt == MAX_CNT - 1'b1);
  end

  // Sample-rate tracking of arming, the period counter and signal presence.
  // A crossing takes priority over the counter saturating on the same sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed    <= 1'b0;
      seen     <= 1'b0;
      cnt      <= '0;
      nosignal <= 1'b1;
    end else if (enableclk) begin
      if (crossing) begin
        armed <= 1'b0;
        seen  <= 1'b1;
        cnt   <= CNT_WIDTH'(1);
        if (launch) begin
          nosignal <= 1'b0;
        end
      end else begin
        if (is_low) begin
          armed <= 1'b1;
        end
        if (cnt != MAX_CNT) begin
          cnt <= cnt + 1'b1;
        end
        if (saturating) begin
          nosignal <= 1'b1;
          seen     <= 1'b0;
        end
      end
    end
  end

  // Divider sequencing state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Start the divider on an accepted crossing and wait for its final step.
  // One DONE clock then publishes the quotient.
  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          next_state = DIV;
          div_start  = 1'b1;
        end
      end
      DIV: begin
        if (div_done) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The output pulses are registered here so each is exactly one clock wide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phaseinc_est <= '0;
      est_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      est_valid <= (state == DONE);
      overrun   <= accepted && fsm_busy;
      if (state == DONE) begin
        phaseinc_est <= div_quotient;
      end
    end
  end

  serial_divider u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .numerator (NUMERATOR),
    .divisor   (cnt),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient)
  );

endmodule

// File: doc/fm_zc_demod.md
# fm_zc_demod

Zero-crossing FM demodulator: the receive-side counterpart of the `dds` phase-accumulator sine generator. It takes signed sine samples at the `enableclk` sample rate and measures the number of samples between rising zero crossings. It converts that period back into the estimated `dds` phase increment, phaseinc = 2^NBITS_PHASE / period, using a serial divider. It sits after the ADC/sample path and feeds the baseband audio path.

## Interface
- NBITS_PHASE, 18, phase accumulator width of the matching transmitter; numerator = 2^NBITS_PHASE.
- N_INPUT_BITS, 8, signed sample width.
- HYST, 4, arming threshold (magnitude, LSBs).
- MIN_PERIOD, 4, shortest accepted period in samples.
- MAX_PERIOD, 65535, period counter saturation / loss-of-signal limit.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- enableclk  in  1  sample strobe; `insine` is valid when high.
- insine  in  N_INPUT_BITS  two's-complement sample.
- phaseinc_est  out  32  last phase-increment estimate. Reset value 0.
- est_valid  out  1  one-cycle pulse when `phaseinc_est` updates. Reset value 0.
- nosignal  out  1  high while no valid crossing has occurred for MAX_PERIOD samples. Reset value 1.
- overrun  out  1  one-cycle pulse when a crossing is dropped because the divider is busy. Reset value 0.

## Operation
- All logic except the divider advances only on edges where `enableclk`=1.
- Arming: `armed` is set when insine ≤ -HYST.
- Crossing: armed=1 and insine ≥ 0. At a crossing, `armed` is cleared on the same edge.
- Period counter `cnt` (16 bits) is the number of samples since the last crossing, counting the crossing sample as 1.
  - It resets to 1 on a crossing sample.
  - It saturates at MAX_PERIOD.
  - A pure period-P input therefore yields P.
- First crossing after reset (flag `seen`=0) only starts counting; no division is launched.
- Crossing with `seen`=1:
  - Period in [MIN_PERIOD, MAX_PERIOD-1] and divider idle: launch the divide and clear `nosignal`.
  - Period < MIN_PERIOD: discard silently.
  - Divider busy: discard and pulse `overrun`.
- When `cnt` reaches MAX_PERIOD: set `nosignal` and clear `seen`. `phaseinc_est` holds its last value.
- FSM states:
  - IDLE: on a launch, go to DIV, load the divisor, clear the remainder, set iter=0.
  - DIV: one restoring-division step per clock, regardless of `enableclk`. After iter=31, go to DONE.
  - DONE: write `phaseinc_est` = quotient, pulse `est_valid`, return to IDLE.
- Arithmetic: unsigned 32/16 restoring division.
  - Numerator = 1<<NBITS_PHASE. Quotient is floored and zero-extended to 32 bits.
  - Remainder register is 17 bits.
- A crossing and a counter saturation on the same edge: the crossing wins.

## Timing
- Crossing detected at edge E0 → 32 DIV edges (E1..E32) → `phaseinc_est` and `est_valid` are registered at E33. Latency = 33 clocks, independent of `enableclk` duty.
- `est_valid` and `overrun` are exactly one clock wide.
- The divider is busy from E1 through E33 inclusive. A crossing on any of those edges is an overrun.
- Reset asserted mid-divide: all outputs return to their reset values immediately (asynchronously). The FSM returns to IDLE. No `est_valid` is produced for the aborted division.

## Structure
- Package `fm_demod_pkg`:
  - FSM state enum (IDLE, DIV, DONE).
  - Default NBITS_PHASE and N_INPUT_BITS constants, shared with `dds` instantiations.
  - Counter width constant (16).
- Sub-module `serial_divider`:
  - Ports: start, numerator, divisor, busy, done, quotient.
  - Fixed 32 iterations.
  - Keeps the top-level FSM responsible only for sequencing.

## Test plan
- Square-wave stimulus: +64 for 32 samples, then -64 for 32 samples, `enableclk`=1 every clock. Expect the first `est_valid` 33 clocks after the second rising crossing, with `phaseinc_est`=4096 (262144/64).
- Period-100 sine with `enableclk` high every 3rd clock → `phaseinc_est`=2621. Repeated every period; no `overrun`.
- Noise toggling between -1 and +2 with HYST=4 → no arming. After 65535 samples `nosignal`=1, and `phaseinc_est` is unchanged.
- Period-20 input with `enableclk`=1 every clock (crossings arrive faster than the 33-clock divider) → alternate crossings are dropped. Each dropped crossing gives an `overrun` pulse; the estimates that complete are correct for the measured periods.
- Reset pulse at E10 of a divide → all outputs return to reset values with no `est_valid`. After release, the first crossing only arms `seen`; the second produces a correct estimate.
- Glitch at 2-sample spacing (< MIN_PERIOD) → discarded silently: no `est_valid`, no `overrun`.
